// File: rtl/seq_tx_pkg.sv
// Shared types and payload tables for the seq_tx serial stimulus transmitter.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        CmdIdle  = 2'b00,
        CmdPulse = 2'b01,
        CmdLock  = 2'b10,
        CmdClear = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap
    } state_e;

    localparam int unsigned PAYLOAD_SLOTS = 3;

    // Serial bit driven on x for a given command and payload slot (0..2).
    function automatic logic payload_bit(cmd_e cmd, logic [1:0] slot);
        logic bit_v;
        bit_v = 1'b0;
        unique case (cmd)
            CmdPulse: bit_v = (slot == 2'd0) || (slot == 2'd1);
            CmdLock:  bit_v = (slot == 2'd0);
            CmdIdle:  bit_v = 1'b0;
            CmdClear: bit_v = 1'b0;
            default:  bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

    // Detector response {a,b} expected at the slot-2 strobe.
    function automatic logic [1:0] expected_ab(cmd_e cmd);
        logic [1:0] ab;
        ab = 2'b00;
        unique case (cmd)
            CmdPulse: ab = 2'b01;
            CmdLock:  ab = 2'b10;
            CmdIdle:  ab = 2'b00;
            CmdClear: ab = 2'b00;
            default:  ab = 2'b00;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/seq_tx_bit_timer.sv
// Per-slot cycle counter; stb marks the last cycle of each bit slot.
module seq_tx_bit_timer #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic stb
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign stb = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_tx.sv
// Serial stimulus transmitter: 3-slot payload + zero gap per command.
// Define SEQ_TX_CHECK_EN to enable the sticky detector-response checker (err).
module seq_tx
    import seq_tx_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 4,
    parameter int unsigned GAP_BITS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_code,
    output logic       cmd_ready,
    output logic       x,
    output logic       x_stb,
    output logic       rx_rst,
    output logic       busy,
    output logic       done,
    input  logic       a_in,
    input  logic       b_in,
    output logic       err
);

    localparam int unsigned SLOT_MAX = (GAP_BITS > PAYLOAD_SLOTS) ? GAP_BITS : PAYLOAD_SLOTS;
    localparam int unsigned SW = $clog2(SLOT_MAX);
    localparam logic [SW-1:0] LAST_PAYLOAD = SW'(PAYLOAD_SLOTS - 1);
    localparam logic [SW-1:0] LAST_GAP = SW'(GAP_BITS - 1);

    state_e        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d, slot_inc;
    cmd_e          cmd_q, cmd_d;
    logic          x_q, x_d;
    logic          rx_rst_q, rx_rst_d;
    logic          stb;
    logic          accept;

    seq_tx_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk(clk),
        .rst(rst),
        .en (busy),
        .clr(!busy),
        .stb(stb)
    );

    assign busy      = (state_q != StIdle);
    assign cmd_ready = (state_q == StIdle) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign slot_inc  = slot_q + SW'(1);
    assign x         = x_q;
    assign rx_rst    = rx_rst_q;
    assign x_stb     = stb;
    assign done      = stb && (state_q == StGap) && (slot_q == LAST_GAP);

    // x and rx_rst are loaded one cycle ahead so they change only on slot boundaries.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        cmd_d    = cmd_q;
        x_d      = x_q;
        rx_rst_d = rx_rst_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StSend;
                    slot_d   = '0;
                    cmd_d    = cmd_e'(cmd_code);
                    x_d      = payload_bit(cmd_e'(cmd_code), 2'd0);
                    rx_rst_d = (cmd_e'(cmd_code) == CmdClear);
                end
            end
            StSend: begin
                if (stb) begin
                    rx_rst_d = 1'b0;
                    if (slot_q == LAST_PAYLOAD) begin
                        state_d = StGap;
                        slot_d  = '0;
                        x_d     = 1'b0;
                    end else begin
                        slot_d = slot_inc;
                        x_d    = payload_bit(cmd_q, 2'(slot_inc));
                    end
                end
            end
            StGap: begin
                if (stb) begin
                    if (slot_q == LAST_GAP) begin
                        state_d = StIdle;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_inc;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                slot_d   = '0;
                x_d      = 1'b0;
                rx_rst_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            slot_q   <= '0;
            cmd_q    <= CmdIdle;
            x_q      <= 1'b0;
            rx_rst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            cmd_q    <= cmd_d;
            x_q      <= x_d;
            rx_rst_q <= rx_rst_d;
        end
    end

`ifdef SEQ_TX_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((state_q == StSend) && stb && (slot_q == LAST_PAYLOAD)
            && ({a_in, b_in} != expected_ab(cmd_q))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_ab;
    assign unused_ab = a_in ^ b_in;
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_seq_tx.sv
// Scoreboard bench for seq_tx: a frame-level model queues expected per-cycle outputs.
module tb_seq_tx;

    localparam int unsigned B = 4;
    localparam int unsigned G = 2;
    localparam int unsigned FRAME = (3 + G) * B;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, a_in, b_in;
    logic [1:0] cmd_code;
    logic       cmd_ready, x, x_stb, rx_rst, busy, done, err;

    always #5 clk = ~clk;

    seq_tx #(
        .BIT_CYCLES(B),
        .GAP_BITS  (G)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .cmd_ready(cmd_ready),
        .x        (x),
        .x_stb    (x_stb),
        .rx_rst   (rx_rst),
        .busy     (busy),
        .done     (done),
        .a_in     (a_in),
        .b_in     (b_in),
        .err      (err)
    );

    typedef struct packed {
        logic       x;
        logic       stb;
        logic       rx_rst;
        logic       done;
        logic       chk;
        logic [1:0] ab;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_acc = 0;
    logic       checking = 1'b0;
    logic       in_frame = 1'b0;
    logic       exp_err = 1'b0;
    logic       cur_chk = 1'b0;
    logic [1:0] cur_ab = 2'b00;

    task automatic check(input string name, input logic act, input logic want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, want);
        end
    endtask

    // One entry per clock cycle of the frame, derived from the slot rules.
    function automatic void push_frame(input logic [1:0] code);
        for (int s = 0; s < 3 + G; s++) begin
            for (int c = 0; c < B; c++) begin
                exp_t e;
                e.x      = (code == 2'b01 && s < 2) || (code == 2'b10 && s == 0);
                e.rx_rst = (code == 2'b11) && (s == 0);
                e.stb    = (c == B - 1);
                e.done   = e.stb && (s == 2 + G);
                e.chk    = e.stb && (s == 2);
                e.ab     = (code == 2'b01) ? 2'b01 : (code == 2'b10) ? 2'b10 : 2'b00;
                exp_q.push_back(e);
            end
        end
    endfunction

    // Model: acceptance happens on an edge ending a cycle with no frame in flight.
    always @(posedge clk) begin
        if (rst) begin
            checking <= 1'b1;
            exp_q.delete();
            exp_err <= 1'b0;
        end else begin
            if (!in_frame && cmd_valid) begin
                push_frame(cmd_code);
                n_acc++;
            end
`ifdef SEQ_TX_CHECK_EN
            if (cur_chk && ({a_in, b_in} != cur_ab)) exp_err <= 1'b1;
`endif
        end
    end

    // Monitor: one queue entry per busy cycle, idle values otherwise.
    always @(negedge clk) begin
        if (checking) begin
            exp_t e;
            logic f;
            f = (exp_q.size() != 0);
            if (f) e = exp_q.pop_front();
            else e = '0;
            in_frame = f;
            cur_chk  = e.chk;
            cur_ab   = e.ab;
            check("busy", busy, f);
            check("x", x, e.x);
            check("x_stb", x_stb, e.stb);
            check("rx_rst", rx_rst, e.rx_rst);
            check("done", done, e.done);
            check("cmd_ready", cmd_ready, !f && !rst);
            check("err", err, exp_err);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] code, input logic hold);
        int start;
        start     = n_acc;
        cmd_valid = 1'b1;
        cmd_code  = code;
        for (int i = 0; i < 200 && n_acc == start; i++) @(negedge clk);
        if (n_acc == start) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout code=%b: got no acceptance expected one", code);
        end
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    initial begin
        a_in = 1'b0;
        b_in = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            {a_in, b_in} = 2'($urandom);
        end
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_code  = 2'b00;
        cycles(3);
        rst = 1'b0;
        cycles(3);

        send(2'b01, 1'b0);
        send(2'b10, 1'b0);
        send(2'b00, 1'b0);
        send(2'b11, 1'b0);
        send(2'b01, 1'b0);

        // Back-to-back with valid held; code churn while busy must not matter.
        send(2'b10, 1'b1);
        send(2'b01, 1'b1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            cmd_code = 2'($urandom);
        end

        // Reset during payload slot 1.
        send(2'b01, 1'b0);
        cycles(B);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        send(2'b10, 1'b0);

        for (int i = 0; i < 600; i++) begin
            cycles(1);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_code  = 2'($urandom);
            rst       = ($urandom_range(0, 63) == 0);
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cycles(FRAME + 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
